// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for the serial add/subtract sequencer.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs; no buffering.
//
// Signals:
//   in_valid  / in_ready   operand pair handshake (producer -> sequencer)
//   op_sub, a_in, b_in     operation select and operands, sampled on accept
//   out_valid / out_ready  result handshake (sequencer -> consumer)
//   sum_out, carry_out,    registered result, final carry, signed overflow
//   ovf_out
//   busy                   sequencer is working on or holding a result
interface serial_add_seq_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             ovf_out;
    logic             busy;

    // Producer/consumer side.
    modport master (
        output in_valid, op_sub, a_in, b_in, out_ready,
        input  in_ready, out_valid, sum_out, carry_out, ovf_out, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, op_sub, a_in, b_in, out_ready,
        output in_ready, out_valid, sum_out, carry_out, ovf_out, busy
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one WIDTH-bit operand pair in, one result out, one bit per clock.
// Latency: out_valid rises WIDTH edges after the operand-accept edge; one result per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid & out_ready.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    slave side of serial_add_seq_if (operand and result handshakes, busy)
module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    serial_add_seq_if.slave bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    // The single full-adder cell every bit passes through.
    logic bit_sum;
    logic bit_cout;

    always_comb begin
        bit_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        bit_cout = (a_sh_q[0] & b_sh_q[0]) |
                   (a_sh_q[0] & carry_q)   |
                   (b_sh_q[0] & carry_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
                    a_sh_d  = bus.a_in;
                    b_sh_d  = bus.op_sub ? ~bus.b_in : bus.b_in;
                    carry_d = bus.op_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                carry_d  = bit_cout;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {bit_sum, res_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // This cycle processes the MSB: carry_q is the carry into it,
                    // bit_cout the carry out of it.
                    sum_d   = {bit_sum, res_sh_q[WIDTH-1:1]};
                    cout_d  = bit_cout;
                    ovf_d   = carry_q ^ bit_cout;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are pure state decodes; result outputs come straight from flops.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.busy      = (state_q != S_IDLE);
        bus.sum_out   = sum_q;
        bus.carry_out = cout_q;
        bus.ovf_out   = ovf_q;
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized and directed bench for serial_add_seq against an arithmetic reference model.
// Latency: checks out_valid rises WIDTH edges after operand accept.
// Backpressure: holds out_ready low in DONE and pulses in_valid while busy.
module tb_serial_add_seq;

    localparam int W     = 4;
    localparam int HALF  = 1 << (W - 1);
    localparam int RANGE = 1 << W;

    logic clk;
    logic reset;

    serial_add_seq_if #(.WIDTH(W)) ifc ();

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - RANGE : v;
    endfunction

    function automatic logic [W-1:0] exp_sum(input int a, input int b, input bit sub);
        int r;
        r = sub ? (a - b) : (a + b);
        return W'(((r % RANGE) + RANGE) % RANGE);
    endfunction

    function automatic bit exp_cout(input int a, input int b, input bit sub);
        return sub ? (a >= b) : ((a + b) >= RANGE);
    endfunction

    function automatic bit exp_ovf(input int a, input int b, input bit sub);
        int r;
        r = sub ? to_signed(a) - to_signed(b) : to_signed(a) + to_signed(b);
        return (r < -HALF) || (r > HALF - 1);
    endfunction

    bit           m_busy;
    bit           m_done;
    int           m_wait;
    int           m_a;
    int           m_b;
    bit           m_sub;
    logic [W-1:0] m_sum;
    bit           m_cout;
    bit           m_ovf;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_wait <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (!m_busy) begin
            if (ifc.in_valid) begin
                m_a    <= int'(ifc.a_in);
                m_b    <= int'(ifc.b_in);
                m_sub  <= ifc.op_sub;
                m_busy <= 1'b1;
                m_wait <= W;
            end
        end else if (m_wait > 1) begin
            m_wait <= m_wait - 1;
        end else if (m_wait == 1) begin
            m_wait <= 0;
            m_done <= 1'b1;
            m_sum  <= exp_sum(m_a, m_b, m_sub);
            m_cout <= exp_cout(m_a, m_b, m_sub);
            m_ovf  <= exp_ovf(m_a, m_b, m_sub);
        end else if (m_done && ifc.out_ready) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  ifc.in_ready,  !m_busy);
            chk("out_valid", ifc.out_valid, m_done);
            chk("busy",      ifc.busy,      m_busy);
            chk("sum_out",   ifc.sum_out,   m_sum);
            chk("carry_out", ifc.carry_out, m_cout);
            chk("ovf_out",   ifc.ovf_out,   m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        int n;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("send_wait_in_ready", ifc.in_ready, 1);
        ifc.in_valid = 1'b1;
        ifc.a_in     = a;
        ifc.b_in     = b;
        ifc.op_sub   = sub;
        step();
        ifc.in_valid = 1'b0;
        ifc.a_in     = W'($urandom);
        ifc.b_in     = W'($urandom);
        ifc.op_sub   = 1'($urandom);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                         input int hold, input bit lit,
                         input logic [W-1:0] es, input bit ec, input bit eo);
        int k;
        send(a, b, sub);
        // Noise on in_valid/out_ready while running must be ignored.
        k = 0;
        do begin
            ifc.in_valid  = 1'($urandom);
            ifc.a_in      = W'($urandom);
            ifc.b_in      = W'($urandom);
            ifc.out_ready = 1'($urandom);
            step();
            k++;
        end while (ifc.out_valid !== 1'b1 && k < 40);
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b0;
        chk("latency", k, W);
        if (lit) begin
            chk("lit_sum",   ifc.sum_out,   es);
            chk("lit_carry", ifc.carry_out, ec);
            chk("lit_ovf",   ifc.ovf_out,   eo);
        end
        for (int i = 0; i < hold; i++) begin
            ifc.in_valid = 1'($urandom);
            ifc.a_in     = W'($urandom);
            ifc.b_in     = W'($urandom);
            step();
            if (lit) begin
                chk("hold_sum",      ifc.sum_out,   es);
                chk("hold_in_ready", ifc.in_ready,  0);
                chk("hold_valid",    ifc.out_valid, 1);
            end
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        chk("idle_after_accept", ifc.in_ready, 1);
        chk("valid_after_accept", ifc.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.op_sub    = 1'b0;
        ifc.a_in      = '0;
        ifc.b_in      = '0;
        ifc.out_ready = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        chk("rst_in_ready",  ifc.in_ready,  1);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_busy",      ifc.busy,      0);
        chk("rst_sum",       ifc.sum_out,   0);
        chk("rst_carry",     ifc.carry_out, 0);
        chk("rst_ovf",       ifc.ovf_out,   0);
        reset = 1'b0;
        step();

        // Hand-computed cases pinning both DUT and model.
        do_op(4'd5,  4'd3, 1'b0, 0, 1'b1, 4'd8,    1'b0, 1'b1);
        do_op(4'd15, 4'd1, 1'b0, 0, 1'b1, 4'd0,    1'b1, 1'b0);
        do_op(4'd7,  4'd1, 1'b0, 0, 1'b1, 4'd8,    1'b0, 1'b1);
        do_op(4'd3,  4'd5, 1'b1, 0, 1'b1, 4'b1110, 1'b0, 1'b0);
        do_op(4'd5,  4'd3, 1'b1, 0, 1'b1, 4'd2,    1'b1, 1'b0);
        chk("model_sum_5m3", m_sum, 4'd2);

        // Backpressure: result held for 6 cycles with in_valid noise.
        do_op(4'd5,  4'd3, 1'b0, 6, 1'b1, 4'd8,    1'b0, 1'b1);

        // Abort: reset sampled on the second RUN edge.
        send(4'd2, 4'd3, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_in_ready", ifc.in_ready, 1);
        chk("abort_busy",     ifc.busy,     0);
        for (int i = 0; i < W + 2; i++) begin
            step();
            chk("abort_no_valid", ifc.out_valid, 0);
        end
        do_op(4'd2, 4'd2, 1'b0, 0, 1'b1, 4'd4, 1'b0, 1'b0);

        // Randomized operations against the model.
        for (int n = 0; n < 150; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  1'b0, '0, 1'b0, 1'b0);
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
